// File: rtl/video_pkg.sv
// Shared video types and constants for the pattern generators.
// Border overlay in bounce_box_pg is enabled with BOUNCE_BORDER_EN.
package video_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic {
    DIR_POS = 1'b0,
    DIR_NEG = 1'b1
  } dir_e;

  localparam int H_AREA = 640;
  localparam int V_AREA = 480;

  localparam logic [7:0] BG_GREY = 8'h20;

  localparam rgb_t PALETTE [8] = '{
    24'hFFFFFF, 24'hFF0000, 24'h00FF00, 24'h0000FF,
    24'hFFFF00, 24'h00FFFF, 24'hFF00FF, 24'hFF8000
  };

endpackage

// File: rtl/bounce_axis.sv
// One axis of the bouncing box: position and direction.
// Updates only on an unpaused frame tick; flip pulses on a wall hit.
module bounce_axis
  import video_pkg::*;
#(
  parameter int AREA = 640,
  parameter int BOX  = 32
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        tick,
  input  logic        pause,
  input  logic [10:0] step,
  output logic [9:0]  pos,
  output logic        flip
);

  localparam logic [10:0] LIM = 11'(AREA - BOX);

  logic [9:0]  pos_q, pos_d;
  dir_e        dir_q, dir_d;
  logic [10:0] sum;

  assign sum = {1'b0, pos_q} + step;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      pos_q <= '0;
      dir_q <= DIR_POS;
    end else begin
      pos_q <= pos_d;
      dir_q <= dir_d;
    end
  end

  always_comb begin
    pos_d = pos_q;
    dir_d = dir_q;
    flip  = 1'b0;
    if (tick && !pause) begin
      unique case (dir_q)
        DIR_POS: begin
          if (sum >= LIM) begin
            pos_d = LIM[9:0];
            dir_d = DIR_NEG;
            flip  = 1'b1;
          end else begin
            pos_d = sum[9:0];
          end
        end
        DIR_NEG: begin
          if ({1'b0, pos_q} <= step) begin
            pos_d = '0;
            dir_d = DIR_POS;
            flip  = 1'b1;
          end else begin
            pos_d = pos_q - step[9:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign pos = pos_q;

endmodule

// File: rtl/bounce_box_pg.sv
// Bouncing-box pattern generator behind the vtc; 1-cycle output latency.
// Define BOUNCE_BORDER_EN to draw a white frame around the active area.
module bounce_box_pg
  import video_pkg::*;
#(
  parameter int hArea = H_AREA,
  parameter int vArea = V_AREA,
  parameter int BOX   = 32,
  parameter int STEP  = 2
) (
  input  logic       clock,
  input  logic       rst,
  input  logic [9:0] hPixel,
  input  logic [9:0] vLine,
  input  logic       vActive,
  input  logic       hSync,
  input  logic       vSync,
  input  logic [2:0] SW,
  output logic [7:0] RED,
  output logic [7:0] GRN,
  output logic [7:0] BLU,
  output logic       hSyncOut,
  output logic       vSyncOut
);

  logic        tick;
  logic [10:0] step;
  logic [9:0]  x, y;
  logic        flip_x, flip_y;
  logic [2:0]  colour_q, colour_d;
  rgb_t        rgb_q, rgb_d;
  logic        hs_q, vs_q;
  logic        in_x, in_y;

  // First blanking line, so the box never moves mid-frame.
  assign tick = (vLine == 10'(vArea)) && (hPixel == '0);
  assign step = SW[1] ? 11'(2 * STEP) : 11'(STEP);

  bounce_axis #(.AREA(hArea), .BOX(BOX)) u_x (
    .clock (clock),
    .rst   (rst),
    .tick  (tick),
    .pause (SW[0]),
    .step  (step),
    .pos   (x),
    .flip  (flip_x)
  );

  bounce_axis #(.AREA(vArea), .BOX(BOX)) u_y (
    .clock (clock),
    .rst   (rst),
    .tick  (tick),
    .pause (SW[0]),
    .step  (step),
    .pos   (y),
    .flip  (flip_y)
  );

  assign colour_d = (flip_x || flip_y) ? colour_q + 3'd1 : colour_q;

  assign in_x = ({1'b0, hPixel} >= {1'b0, x}) &&
                ({1'b0, hPixel} < {1'b0, x} + 11'(BOX));
  assign in_y = ({1'b0, vLine} >= {1'b0, y}) &&
                ({1'b0, vLine} < {1'b0, y} + 11'(BOX));

`ifdef BOUNCE_BORDER_EN
  logic border;
  assign border = (hPixel == '0) || (hPixel == 10'(hArea - 1)) ||
                  (vLine == '0)  || (vLine == 10'(vArea - 1));
`endif

  always_comb begin
    rgb_d = '0;
    if (vActive) begin
      if (in_x && in_y) begin
        rgb_d = PALETTE[colour_q];
      end
`ifdef BOUNCE_BORDER_EN
      else if (border) begin
        rgb_d = 24'hFFFFFF;
      end
`endif
      else if (SW[2]) begin
        rgb_d = '{r: BG_GREY, g: BG_GREY, b: BG_GREY};
      end
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      colour_q <= '0;
      rgb_q    <= '0;
      hs_q     <= 1'b1;
      vs_q     <= 1'b1;
    end else begin
      colour_q <= colour_d;
      rgb_q    <= rgb_d;
      hs_q     <= hSync;
      vs_q     <= vSync;
    end
  end

  assign RED      = rgb_q.r;
  assign GRN      = rgb_q.g;
  assign BLU      = rgb_q.b;
  assign hSyncOut = hs_q;
  assign vSyncOut = vs_q;

endmodule

// File: tb/tb_bounce_box_pg.sv
// Scoreboard bench for bounce_box_pg with a behavioural box model.
// Border expectations follow BOUNCE_BORDER_EN.
module tb_bounce_box_pg;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] hPixel, vLine;
  logic       vActive, hSync, vSync;
  logic [2:0] SW;
  logic [7:0] RED, GRN, BLU;
  logic       hSyncOut, vSyncOut;

  always #5 clk = ~clk;

  bounce_box_pg dut (
    .clock    (clk),
    .rst      (rst),
    .hPixel   (hPixel),
    .vLine    (vLine),
    .vActive  (vActive),
    .hSync    (hSync),
    .vSync    (vSync),
    .SW       (SW),
    .RED      (RED),
    .GRN      (GRN),
    .BLU      (BLU),
    .hSyncOut (hSyncOut),
    .vSyncOut (vSyncOut)
  );

  typedef struct {
    string      tag;
    logic [23:0] rgb;
    logic       hs;
    logic       vs;
  } exp_t;

  exp_t q[$];
  int nchk = 0;
  int nerr = 0;

  logic [23:0] pal [8] = '{
    24'hFFFFFF, 24'hFF0000, 24'h00FF00, 24'h0000FF,
    24'hFFFF00, 24'h00FFFF, 24'hFF00FF, 24'hFF8000
  };

  // behavioural state of the box
  int mx, my, mdx, mdy, mcol;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] exp_pix(int h, int v, bit act);
    bit inb;
    if (!act) return 24'h0;
    inb = (h >= mx) && (h < mx + 32) && (v >= my) && (v < my + 32);
    if (inb) return pal[mcol];
`ifdef BOUNCE_BORDER_EN
    if (h == 0 || h == 639 || v == 0 || v == 479) return 24'hFFFFFF;
`endif
    return SW[2] ? 24'h202020 : 24'h0;
  endfunction

  task automatic drive(input string tag, input int h, input int v,
                       input bit act, input logic [23:0] erg);
    exp_t e;
    exp_t o;
    hPixel  = 10'(h);
    vLine   = 10'(v);
    vActive = act;
    hSync   = 1'($urandom);
    vSync   = 1'($urandom);
    e.tag = tag; e.rgb = erg; e.hs = hSync; e.vs = vSync;
    q.push_back(e);
    @(posedge clk);
    #1;
    o = q.pop_front();
    chk(o.tag, {8'h0, RED, GRN, BLU}, {8'h0, o.rgb});
    chk({o.tag, "_hs"}, {31'h0, hSyncOut}, {31'h0, o.hs});
    chk({o.tag, "_vs"}, {31'h0, vSyncOut}, {31'h0, o.vs});
  endtask

  task automatic pix(input string tag, input int h, input int v, input bit act);
    drive(tag, h, v, act, exp_pix(h, v, act));
  endtask

  task automatic model_axis(inout int p, inout int d, input int lim,
                            input int s, output bit f);
    f = 0;
    if (d == 0) begin
      if (p + s >= lim) begin p = lim; d = 1; f = 1; end
      else p = p + s;
    end else begin
      if (p <= s) begin p = 0; d = 0; f = 1; end
      else p = p - s;
    end
  endtask

  task automatic do_tick(output bit any);
    bit fx, fy;
    int s;
    drive("tick", 0, 480, 1'b0, 24'h0);
    any = 0;
    if (!SW[0]) begin
      s = SW[1] ? 4 : 2;
      model_axis(mx, mdx, 608, s, fx);
      model_axis(my, mdy, 448, s, fy);
      any = fx | fy;
      if (any) mcol = (mcol + 1) % 8;
    end
  endtask

  task automatic probe();
    pix("box_tl", mx, my, 1'b1);
    pix("box_br", mx + 31, my + 31, 1'b1);
    if (mx + 32 < 640) pix("right_of", mx + 32, my, 1'b1);
    if (my + 32 < 480) pix("below", mx, my + 32, 1'b1);
    if (mx > 0) pix("left_of", mx - 1, my + 5, 1'b1);
    if (my > 0) pix("above", mx + 5, my - 1, 1'b1);
  endtask

  task automatic model_reset();
    mx = 0; my = 0; mdx = 0; mdy = 0; mcol = 0;
  endtask

  initial begin
    bit any;
    rst = 1'b1;
    hPixel = '0; vLine = '0; vActive = 1'b0;
    hSync = 1'b0; vSync = 1'b0; SW = 3'b000;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rgb", {8'h0, RED, GRN, BLU}, 32'h0);
    chk("rst_hs", {31'h0, hSyncOut}, 32'h1);
    chk("rst_vs", {31'h0, vSyncOut}, 32'h1);
    rst = 1'b0;

    drive("lat_white", 0, 0, 1'b1, 24'hFFFFFF);
    drive("lat_out", 32, 0, 1'b1, 24'h000000);
    SW = 3'b100;
    drive("lat_grey", 32, 0, 1'b1, 24'h202020);
    drive("lat_inact", 5, 5, 1'b0, 24'h000000);
    pix("corner_in", 31, 31, 1'b1);
    pix("edge_out", 0, 32, 1'b1);
    SW = 3'b000;
`ifdef BOUNCE_BORDER_EN
    drive("border", 639, 200, 1'b1, 24'hFFFFFF);
`else
    drive("border", 639, 200, 1'b1, 24'h000000);
`endif

    SW = 3'b001;
    repeat (3) do_tick(any);
    SW = 3'b000;
    drive("pause_box", 0, 0, 1'b1, 24'hFFFFFF);
    drive("pause_out", 32, 32, 1'b1, 24'h000000);

    SW = 3'b010;
    do_tick(any);
    SW = 3'b000;
    drive("speed_x4", 4, 4, 1'b1, 24'hFFFFFF);
    drive("speed_x3", 3, 4, 1'b1, 24'h000000);
    probe();

    // reset in the middle of a line
    hSync = 1'b0;
    drive("pre_rst", 4, 4, 1'b1, 24'hFFFFFF);
    hPixel = 10'd100; vLine = 10'd10; vActive = 1'b1;
    hSync = 1'b0; vSync = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_rgb", {8'h0, RED, GRN, BLU}, 32'h0);
    chk("mid_rst_hs", {31'h0, hSyncOut}, 32'h1);
    chk("mid_rst_vs", {31'h0, vSyncOut}, 32'h1);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    probe();

    for (int t = 1; t <= 8520; t++) begin
      do_tick(any);
      if (t == 1) begin
        drive("first_tick", 2, 2, 1'b1, 24'hFFFFFF);
        drive("first_tick_lo", 1, 2, 1'b1, 24'h000000);
      end
      if (t == 224) drive("y448_red", 448, 448, 1'b1, 24'hFF0000);
      if (t == 304) drive("x608_grn", 608, 288, 1'b1, 24'h00FF00);
      if (t == 305) begin
        drive("x606", 606, 290, 1'b1, 24'h00FF00);
        drive("x606_r", 638, 290, 1'b1, 24'h000000);
      end
      if (t == 8512)
        drive("corner", 0, 0, 1'b1, pal[mcol]);
      if (any || t <= 2 || t % 500 == 0 || t == 8511)
        probe();
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
